// File: rtl/l1_stream_out.sv
// l1_stream_out: drains layer memory L1 in raster order onto a valid/ready stream
// through a small show-ahead FIFO, tracking the signed maximum and its first address.

module l1_stream_out #(
  parameter int         NUM_WORDS  = 1024,
  parameter int         FIFO_DEPTH = 4,
  parameter logic [2:0] LAYER_SEL  = 3'd3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        crd,
  output logic [11:0] caddr_rd,
  input  logic [19:0] cdata_rd,
  output logic [2:0]  csel,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [19:0] m_data,
  output logic        m_last,
  output logic [19:0] max_val,
  output logic [11:0] max_addr
);

  localparam int               PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int               CNT_W     = PTR_W + 1;
  localparam logic [11:0]      LAST_ADDR = 12'(NUM_WORDS - 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t                state_r;
  state_t                state_nxt_s;
  logic [11:0]           next_addr_r;
  logic [11:0]           issue_addr_s;
  logic                  crd_r;
  logic [11:0]           caddr_r;
  logic [19:0]           fifo_data_r [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_last_r;
  logic [PTR_W-1:0]      wr_ptr_r;
  logic [PTR_W-1:0]      rd_ptr_r;
  logic [CNT_W-1:0]      count_r;
  logic [CNT_W-1:0]      count_nxt_s;
  logic [19:0]           max_val_r;
  logic [11:0]           max_addr_r;
  logic                  max_first_r;
  logic                  start_ok_s;
  logic                  issue_s;
  logic                  push_s;
  logic                  pop_s;
  logic                  room_s;
  logic                  valid_s;
  logic                  head_last_s;
  logic                  busy_s;
  logic                  done_s;
  logic [2:0]            csel_s;

  // Handshake, occupancy and read-issue decisions
  always_comb begin
    valid_s      = (count_r != CNT_W'(0));
    start_ok_s   = (state_r == ST_IDLE) && start;
    push_s       = crd_r;
    pop_s        = valid_s && m_ready;
    head_last_s  = fifo_last_r[rd_ptr_r];
    count_nxt_s  = count_r;
    if (push_s && !pop_s) begin
      count_nxt_s = count_r + CNT_W'(1);
    end else if (!push_s && pop_s) begin
      count_nxt_s = count_r - CNT_W'(1);
    end else begin
      count_nxt_s = count_r;
    end
    // Room is judged on post-edge occupancy; the new read itself becomes the in-flight slot
    room_s       = (count_nxt_s < DEPTH_CNT);
    issue_s      = start_ok_s || ((state_r == ST_READ) && room_s);
    issue_addr_s = start_ok_s ? 12'd0 : next_addr_r;
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nxt_s = (LAST_ADDR == 12'd0) ? ST_DRAIN : ST_READ;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_READ: begin
        if (room_s && (next_addr_r == LAST_ADDR)) begin
          state_nxt_s = ST_DRAIN;
        end else begin
          state_nxt_s = ST_READ;
        end
      end
      ST_DRAIN: begin
        if (pop_s && head_last_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM output decode
  always_comb begin
    busy_s = 1'b0;
    done_s = 1'b0;
    case (state_r)
      ST_IDLE:  busy_s = 1'b0;
      ST_READ:  busy_s = 1'b1;
      ST_DRAIN: busy_s = 1'b1;
      ST_DONE: begin
        busy_s = 1'b1;
        done_s = 1'b1;
      end
      default: busy_s = 1'b0;
    endcase
    csel_s = busy_s ? LAYER_SEL : 3'd0;
  end

  // Read port: strobe and address are registered at issue, address holds otherwise
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      crd_r       <= 1'b0;
      caddr_r     <= 12'd0;
      next_addr_r <= 12'd0;
    end else if (issue_s) begin
      crd_r       <= 1'b1;
      caddr_r     <= issue_addr_s;
      next_addr_r <= issue_addr_s + 12'd1;
    end else begin
      crd_r       <= 1'b0;
    end
  end

  // Show-ahead FIFO; read data is captured the cycle it is presented
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data_r[i] <= 20'd0;
      end
      fifo_last_r <= {FIFO_DEPTH{1'b0}};
      wr_ptr_r    <= PTR_W'(0);
      rd_ptr_r    <= PTR_W'(0);
      count_r     <= CNT_W'(0);
    end else if (start_ok_s) begin
      wr_ptr_r    <= PTR_W'(0);
      rd_ptr_r    <= PTR_W'(0);
      count_r     <= CNT_W'(0);
    end else begin
      if (push_s) begin
        fifo_data_r[wr_ptr_r] <= cdata_rd;
        fifo_last_r[wr_ptr_r] <= (caddr_r == LAST_ADDR);
        wr_ptr_r              <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      count_r <= count_nxt_s;
    end
  end

  // Max tracker: first word loads, later words must be strictly greater so ties keep the lower address
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      max_val_r   <= 20'd0;
      max_addr_r  <= 12'd0;
      max_first_r <= 1'b0;
    end else if (start_ok_s) begin
      max_val_r   <= 20'd0;
      max_addr_r  <= 12'd0;
      max_first_r <= 1'b1;
    end else if (push_s && (max_first_r || ($signed(cdata_rd) > $signed(max_val_r)))) begin
      max_val_r   <= cdata_rd;
      max_addr_r  <= caddr_r;
      max_first_r <= 1'b0;
    end else begin
      max_first_r <= max_first_r;
    end
  end

  assign busy     = busy_s;
  assign done     = done_s;
  assign csel     = csel_s;
  assign crd      = crd_r;
  assign caddr_rd = caddr_r;
  assign m_valid  = valid_s;
  assign m_data   = valid_s ? fifo_data_r[rd_ptr_r] : 20'd0;
  assign m_last   = valid_s && head_last_s;
  assign max_val  = max_val_r;
  assign max_addr = max_addr_r;

endmodule

// File: tb/tb_l1_stream_out.sv
// Scoreboard bench for l1_stream_out: a layer-memory model feeds the DUT, expected
// beats are queued per drain and a negedge monitor pops and compares every transfer.

module tb_l1_stream_out;

  localparam int NW = 1024;
  localparam int FD = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        m_ready = 1'b0;
  logic        busy, done, crd, m_valid, m_last;
  logic [11:0] caddr_rd, max_addr;
  logic [19:0] cdata_rd, m_data, max_val;
  logic [2:0]  csel;

  logic [19:0] mem [0:4095];
  logic [20:0] exp_q [$];
  logic [20:0] mon_exp;
  logic        hold_r = 1'b0;
  logic [20:0] hold_val = 21'd0;
  int          checks = 0;
  int          passes = 0;

  assign cdata_rd = mem[caddr_rd];

  always #5 clk = ~clk;

  l1_stream_out #(.NUM_WORDS(NW), .FIFO_DEPTH(FD), .LAYER_SEL(3'd3)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd), .csel(csel),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .max_val(max_val), .max_addr(max_addr)
  );

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
  endtask

  task automatic check_reset_vals(input string tag);
    check(busy == 1'b0, {tag, "_busy"}, busy, 0);
    check(done == 1'b0, {tag, "_done"}, done, 0);
    check(crd == 1'b0, {tag, "_crd"}, crd, 0);
    check(caddr_rd == 12'd0, {tag, "_caddr"}, caddr_rd, 0);
    check(csel == 3'd0, {tag, "_csel"}, csel, 0);
    check(m_valid == 1'b0, {tag, "_m_valid"}, m_valid, 0);
    check(m_data == 20'd0, {tag, "_m_data"}, m_data, 0);
    check(m_last == 1'b0, {tag, "_m_last"}, m_last, 0);
    check(max_val == 20'd0, {tag, "_max_val"}, max_val, 0);
    check(max_addr == 12'd0, {tag, "_max_addr"}, max_addr, 0);
  endtask

  // Monitor: pop one expected beat per transfer and check stability under back-pressure
  always @(negedge clk) begin
    if (!reset) begin
      hold_r <= 1'b0;
    end else begin
      if (hold_r) check(m_valid && ({m_last, m_data} == hold_val), "hold_stable", {m_last, m_data}, hold_val);
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          check(1'b0, "beat_unexpected", {m_last, m_data}, 0);
        end else begin
          mon_exp = exp_q.pop_front();
          check({m_last, m_data} == mon_exp, "beat", {m_last, m_data}, mon_exp);
        end
      end
      hold_r   <= m_valid && !m_ready;
      hold_val <= {m_last, m_data};
    end
  end

  // mode 0: ready=1; mode 1: stall cycles 4..13 then random; mode 2: random ready
  task automatic run_drain(input int mode, input int extra_start, input int reset_at, input bit chk_timing);
    int best, best_a, done_n, done_cnt, reads;
    logic [19:0] ref_val;
    logic [11:0] ref_addr;
    best = -(1 << 19);
    for (int a = 0; a < NW; a++) begin
      exp_q.push_back({(a == NW - 1), mem[a]});
      if (int'($signed(mem[a])) > best) best = int'($signed(mem[a]));
    end
    best_a = 0;
    for (int a = NW - 1; a >= 0; a--) begin
      if (int'($signed(mem[a])) == best) best_a = a;
    end
    ref_val  = best[19:0];
    ref_addr = best_a[11:0];
    done_n = 0; done_cnt = 0; reads = 0;
    @(posedge clk); #1 start = 1'b1; m_ready = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int n = 1; n < 6000; n++) begin
      case (mode)
        0: m_ready = 1'b1;
        1: m_ready = (n < 4) ? 1'b1 : (n <= 13) ? 1'b0 : ($urandom_range(0, 3) != 0);
        default: m_ready = ($urandom_range(0, 3) != 0);
      endcase
      start = (n == extra_start);
      if (n == reset_at) reset = 1'b0;
      @(negedge clk);
      if (n == reset_at) begin
        check_reset_vals("mid_reset");
        exp_q.delete();
        start = 1'b0;
        repeat (2) @(negedge clk);
        check(busy == 1'b0 && m_valid == 1'b0 && done == 1'b0, "reset_hold", {busy, m_valid, done}, 0);
        reset = 1'b1;
        return;
      end
      if (crd) reads++;
      if (n == 1 && chk_timing) begin
        check(busy == 1'b1, "c1_busy", busy, 1);
        check(crd == 1'b1 && caddr_rd == 12'd0, "c1_read", {crd, caddr_rd}, 13'h1000);
        check(csel == 3'd3, "c1_csel", csel, 3);
      end
      if (mode == 1 && n == 4) check(m_valid && m_data == mem[2], "bp_word2_c4", m_data, mem[2]);
      if (mode == 1 && n == 13) begin
        check(m_valid && m_data == mem[2], "bp_word2_c13", m_data, mem[2]);
        check(reads == FD + 2, "bp_reads_issued", reads, FD + 2);
        check(crd == 1'b0, "bp_crd_stalled", crd, 0);
      end
      if (done) begin
        done_cnt++;
        if (done_n == 0) done_n = n;
      end
      if (done_n != 0 && n == done_n + 1) begin
        check(busy == 1'b0 && csel == 3'd0 && done == 1'b0, "post_done_idle", {busy, csel, done}, 0);
        break;
      end
      @(posedge clk); #1;
    end
    check(done_n != 0, "drain_done_seen", done_n, 1);
    if (chk_timing) check(done_n == NW + 2, "done_cycle", done_n, NW + 2);
    check(done_cnt == 1, "done_pulses", done_cnt, 1);
    check(exp_q.size() == 0, "beats_remaining", exp_q.size(), 0);
    check(max_val == ref_val, "max_val", max_val, ref_val);
    check(max_addr == ref_addr, "max_addr", max_addr, ref_addr);
    exp_q.delete();
  endtask

  initial begin
    for (int a = 0; a < 4096; a++) mem[a] = 20'd0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    reset = 1'b1;

    for (int a = 0; a < NW; a++) mem[a] = 20'(a);
    run_drain(0, 0, 0, 1'b1);

    for (int a = 0; a < NW; a++) mem[a] = 20'($urandom);
    run_drain(1, 0, 0, 1'b0);

    for (int a = 0; a < NW; a++) mem[a] = 20'd0;
    mem[100] = 20'h7FFFF;
    mem[900] = 20'h7FFFF;
    run_drain(2, 0, 0, 1'b0);

    for (int a = 0; a < NW; a++) mem[a] = 20'hFFFFF;
    mem[5] = 20'hFFFFE;
    run_drain(2, 0, 0, 1'b0);

    for (int a = 0; a < NW; a++) mem[a] = 20'($urandom);
    run_drain(0, 300, 0, 1'b1);

    for (int a = 0; a < NW; a++) mem[a] = 20'(a);
    run_drain(0, 0, 500, 1'b0);
    for (int a = 0; a < NW; a++) mem[a] = 20'($urandom) ^ 20'h55555;
    run_drain(0, 0, 0, 1'b1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/l1_stream_out.md
# l1_stream_out

Drains the 32x32 max-pooled feature map (layer memory L1, csel=3) after the convolution engine finishes and streams it to the host over a valid/ready interface in raster order. It also reports the maximum pooled value and its address. It sits directly downstream of the convolution/pooling engine and shares its layer-memory read port (crd/caddr_rd/cdata_rd/csel) once that engine has dropped busy.

## Interface
- NUM_WORDS, 1024: words to drain, addresses 0..NUM_WORDS-1.
- FIFO_DEPTH, 4: output buffer depth, power of two, at least 2.
- LAYER_SEL, 3'd3: csel value driven while draining.
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse that begins a drain; ignored while busy=1.
- busy  output  1  high from the cycle after start is sampled through the done cycle.
- done  output  1  one-cycle pulse when the final beat has been accepted.
- crd  output  1  layer-memory read strobe.
- caddr_rd  output  12  layer-memory read address.
- cdata_rd  input  20  signed layer-memory read data, valid in the same cycle as crd/caddr_rd.
- csel  output  3  layer-memory select: LAYER_SEL while busy, else 0.
- m_valid  output  1  stream data valid.
- m_ready  input  1  stream sink ready.
- m_data  output  20  signed stream word.
- m_last  output  1  high with the word from address NUM_WORDS-1.
- max_val  output  20  signed maximum over the completed drain.
- max_addr  output  12  address of the first occurrence of max_val.

## Operation
- States:
  - IDLE: start=1 goes to READ. Clear the read address, FIFO, in-flight flag and max tracker.
  - READ: issue one read per cycle while (FIFO count + in-flight) < FIFO_DEPTH. After the read of NUM_WORDS-1 issues, go to DRAIN.
  - DRAIN: when the FIFO is empty, no read is in flight and the last beat has been accepted, go to DONE.
  - DONE: one cycle, done=1, then IDLE.
- Issuing a read means registering crd=1 and caddr_rd=addr. At the end of that cycle, cdata_rd is captured into the FIFO tail and the in-flight flag clears. crd=0 in any cycle with no issue; caddr_rd holds its value.
- FIFO is show-ahead. m_valid = !empty. m_data is the head entry. A beat transfers when m_valid && m_ready, which pops the head.
- m_last is stored per entry and is set only for address NUM_WORDS-1.
- Max tracker:
  - The first captured word loads max_val and max_addr.
  - Later words replace them only when strictly greater (signed compare), so ties keep the lower address.
  - Values are final when done pulses and are held until the next start.
- A simultaneous push and pop leaves the count unchanged. Push is never attempted when full; the issue rule guarantees this.
- start during busy has no effect. m_ready while m_valid=0 is ignored.
- reset asserted mid-drain: all state and outputs return to reset values immediately, FIFO contents are discarded, and no done pulse is produced.

## Timing
- Reset values: busy 0, done 0, crd 0, caddr_rd 0, csel 0, m_valid 0, m_data 0, m_last 0, max_val 0, max_addr 0.
- start is sampled at edge E0. Cycle 1 (after E0): busy=1, csel=LAYER_SEL, crd=1, caddr_rd=0.
- With m_ready held at 1: address k is presented in cycle k+1, and word k is on m_data with m_valid=1 in cycle k+2.
  - Word 1023 plus m_last appear in cycle 1025.
  - done=1 in cycle 1026.
  - busy=0 and csel=0 from cycle 1027.
- Throughput is one word per cycle with no bubbles while m_ready=1.
- Back-pressure: m_data and m_last stay stable while m_valid=1 and m_ready=0. Reads stall once count + in-flight reaches FIFO_DEPTH and resume the cycle after a pop frees space.
- done and the first beat of a new drain never overlap; the earliest new start is sampled in the done cycle or later.

## Test plan
- Full drain, m_ready=1, memory word[a]=a: 1024 beats with values 0..1023 in order, m_last only on 1023, done in cycle 1026, max_val=1023, max_addr=1023.
- Back-pressure, m_ready low for 10 cycles from cycle 4:
  - m_data is held at word 2.
  - crd stops after FIFO_DEPTH words are buffered or in flight.
  - No data is lost or duplicated; the stream order matches a reference model.
- Tie handling, word[100]=word[900]=20'h7FFFF and all others 0: max_val=20'h7FFFF, max_addr=100.
- Negative values, all words 20'hFFFFF except word[5]=20'hFFFFE: max_val=-1, max_addr=0.
- start pulsed again at cycle 300 of an active drain: ignored, exactly 1024 beats, single done pulse.
- reset asserted at cycle 500, then released and start reissued:
  - All outputs read reset values during reset.
  - The restarted drain delivers words from address 0 with no stale FIFO data.
